// File: rtl/wb_rf_writer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_pkg : shared load-type codes, width defaults and FIFO entry type
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_rf_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_rf_writer_if : MEM-result input handshake and register-file write port
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
interface wb_rf_writer_if
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic              in_wen;
  logic [ADDR_W-1:0] in_rd;
  logic              in_is_load;
  logic [2:0]        in_ld_type;
  logic [1:0]        in_byte_off;
  logic [DATA_W-1:0] in_alu_data;
  logic [DATA_W-1:0] in_mem_data;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  // Environment side: MEM stage producer and register-file consumer
  modport master (
    output in_valid, in_wen, in_rd, in_is_load, in_ld_type, in_byte_off,
           in_alu_data, in_mem_data, rf_ready,
    input  in_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  in_valid, in_wen, in_rd, in_is_load, in_ld_type, in_byte_off,
           in_alu_data, in_mem_data, rf_ready,
    output in_ready, rf_we, rf_waddr, rf_wdata
  );

endinterface
`default_nettype wire

// File: rtl/wb_rf_writer_load_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_load_align : extracts and sign/zero-extends the loaded byte/half/word
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W
) (
  input  logic [2:0]        ld_type_i,
  input  logic [1:0]        byte_off_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0] half_w;
  logic [7:0]  byte_w;

  always_comb begin
    half_w = byte_off_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    byte_w = mem_data_i[{byte_off_i, 3'b000} +: 8];
    data_o = mem_data_i;
    // Reserved encodings fall through to the full-word default
    case (ld_type_i)
      LT_LH:   data_o = {{(DATA_W-16){half_w[15]}}, half_w};
      LT_LHU:  data_o = {{(DATA_W-16){1'b0}}, half_w};
      LT_LB:   data_o = {{(DATA_W-8){byte_w[7]}}, byte_w};
      LT_LBU:  data_o = {{(DATA_W-8){1'b0}}, byte_w};
      default: data_o = mem_data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_rf_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_rf_writer : writeback FIFO driving the register-file write port.
// Optional bypass search enabled by defining WB_BYPASS_EN.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module wb_rf_writer
  import wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_rf_writer_if.slave          bus,
  output logic [$clog2(DEPTH):0] pending_cnt,
  input  logic [ADDR_W-1:0]      byp_raddr,
  output logic                   byp_hit,
  output logic [DATA_W-1:0]      byp_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t          fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DATA_W-1:0]  ld_data;
  logic [DATA_W-1:0]  wdata_sel;
  logic               accept;
  logic               push;
  logic               pop;

  wb_load_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .ld_type_i  (bus.in_ld_type),
    .byte_off_i (bus.in_byte_off),
    .mem_data_i (bus.in_mem_data),
    .data_o     (ld_data)
  );

  assign wdata_sel    = bus.in_is_load ? ld_data : bus.in_alu_data;

  // A full FIFO still accepts when the head drains in the same cycle
  assign bus.in_ready = (cnt_q < CNT_W'(DEPTH)) || bus.rf_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = accept && bus.in_wen && (bus.in_rd != '0);
  assign pop          = bus.rf_we && bus.rf_ready;

  assign bus.rf_we    = (cnt_q != '0);
  assign bus.rf_waddr = fifo_q[rd_ptr_q].addr;
  assign bus.rf_wdata = fifo_q[rd_ptr_q].data;
  assign pending_cnt  = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q].addr <= bus.in_rd;
        fifo_q[wr_ptr_q].data <= wdata_sel;
      end
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match left standing is the youngest
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt_q) && (byp_raddr != '0) &&
          (fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].addr == byp_raddr)) begin
        byp_hit  = 1'b1;
        byp_data = fifo_q[PTR_W'(rd_ptr_q + PTR_W'(i))].data;
      end
    end
  end
`else
  logic unused_byp_raddr;
  assign unused_byp_raddr = ^byp_raddr;
  assign byp_hit          = 1'b0;
  assign byp_data         = '0;
`endif

endmodule
`default_nettype wire
